// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, state encoding and shared constants for the HI/LO multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU op codes).
`default_nettype none

package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int          MDU_CYCLES = 32;
    localparam logic [31:0] DIV0_LO    = 32'hFFFFFFFF;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return (op <= OP_MADDU);
`else
        return (op <= OP_DIVU);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-divide step on a {remainder, quotient} pair.
`default_nettype none

module mdu_divstep (
    input  logic [63:0] rq_i,
    input  logic [31:0] divisor_i,
    output logic [63:0] rq_o
);

    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_sub;

    // Remainder is always below the divisor, so the shifted value fits in 33 bits
    // and the difference (when taken) fits back in 32.
    assign w_rem_sh = rq_i[63:31];
    assign w_ge     = (w_rem_sh >= {1'b0, divisor_i});
    assign w_sub    = w_rem_sh[31:0] - divisor_i;
    assign rq_o     = w_ge ? {w_sub, rq_i[30:0], 1'b1}
                           : {w_rem_sh[31:0], rq_i[30:0], 1'b0};

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle HI/LO multiply/divide unit with MTHI/MTLO writes.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into {Hi,Lo}).
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int CYCLES = MDU_CYCLES
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        HiWr,
    input  logic        LoWr,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int CNT_W = $clog2(CYCLES) + 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      b_q, b_d;
    logic [63:0]      acc_q, acc_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;
`ifdef MDU_MADD_EN
    logic             madd_q, madd_d;
`endif

    logic        w_accept, w_is_div, w_signed, w_sa, w_sb, w_div0;
    logic [31:0] w_mag_a, w_mag_b;
    logic [32:0] w_msum;
    logic [63:0] w_mstep, w_dstep, w_prod, w_mres;
    logic [31:0] w_quo, w_rem;

    assign w_is_div = (Op == OP_DIV) || (Op == OP_DIVU);
    assign w_signed = ~Op[0];
    assign w_sa     = w_signed & RsData[31];
    assign w_sb     = w_signed & RtData[31];
    assign w_mag_a  = w_sa ? -RsData : RsData;
    assign w_mag_b  = w_sb ? -RtData : RtData;
    assign w_div0   = w_is_div && (RtData == 32'd0);
    // MTHI/MTLO take priority over a launch in the same cycle.
    assign w_accept = (state_q == ST_IDLE) && Start && op_legal(Op) && !HiWr && !LoWr;

    // Shift-add: multiplier sits in the low half and drains out as the product fills in.
    assign w_msum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign w_mstep = {w_msum, acc_q[31:1]};

    mdu_divstep u_divstep (
        .rq_i      (acc_q),
        .divisor_i (b_q),
        .rq_o      (w_dstep)
    );

    assign w_prod = neg_q ? -acc_q : acc_q;
`ifdef MDU_MADD_EN
    assign w_mres = madd_q ? ({hi_q, lo_q} + w_prod) : w_prod;
`else
    assign w_mres = w_prod;
`endif
    assign w_quo  = neg_q     ? -acc_q[31:0]  : acc_q[31:0];
    assign w_rem  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b_d       = b_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MDU_MADD_EN
        madd_d    = madd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (HiWr) hi_d = RsData;
                if (LoWr) lo_d = RsData;
                if (w_accept) begin
                    is_div_d  = w_is_div;
                    neg_d     = w_sa ^ w_sb;
                    neg_rem_d = w_sa;
                    div0_d    = w_div0;
                    cnt_d     = '0;
`ifdef MDU_MADD_EN
                    madd_d    = Op[2];
`endif
                    if (w_div0) begin
                        acc_d   = {RsData, DIV0_LO};
                        state_d = ST_FIX;
                    end else begin
                        acc_d   = w_is_div ? {32'd0, w_mag_a} : {32'd0, w_mag_b};
                        b_d     = w_is_div ? w_mag_b : w_mag_a;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? w_dstep : w_mstep;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CYCLES - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (div0_q)        {hi_d, lo_d} = acc_q;
                else if (is_div_q) {hi_d, lo_d} = {w_rem, w_quo};
                else               {hi_d, lo_d} = w_mres;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MDU_MADD_EN
            madd_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MDU_MADD_EN
            madd_q    <= madd_d;
`endif
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit sitting directly downstream of the register file.
- Consumes RsData/RtData and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds results in HI/LO for MFHI/MFLO. The pipeline stalls on Busy.

Parameters:
- CYCLES, 32, number of iteration steps per operation; fixed equal to the data width.

Ports:
- Clk  input  1  system clock, rising-edge
- Rst  input  1  asynchronous, active-high reset
- Start  input  1  launch request; sampled only in IDLE
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU; others illegal
- RsData  input  32  operand A (dividend / multiplicand), from RegFile RsData
- RtData  input  32  operand B (divisor / multiplier), from RegFile RtData
- HiWr  input  1  MTHI: HI <= RsData
- LoWr  input  1  MTLO: LO <= RsData
- Busy  output  1  high while an operation is in flight
- Done  output  1  one-cycle pulse when HI/LO are updated by an operation
- Hi  output  32  HI register
- Lo  output  32  LO register

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE; Busy = 0; Done = 0; Hi = 0; Lo = 0; iteration counter = 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start with a legal Op at edge E0: latch the operand magnitudes and the sign flags, then go to CALC.
  - Signed ops take absolute values; unsigned ops take operands as-is.
  - Illegal Op: Start is ignored and the unit stays in IDLE.
- CALC:
  - Edges E1..E32 each perform one step: shift-add for multiply, restoring subtract-shift for divide.
  - At E32 go to FIX.
- FIX:
  - At E33, apply the sign correction and write Hi/Lo.
  - Done = 1 for the cycle after E33; go to IDLE.
- Latency: 33 edges from the accepting edge to the result.
- Busy = (state != IDLE). It is combinational from state, so it is high from just after E0 until just after E33.
- Multiply: {Hi,Lo} = 64-bit product. For signed ops, negate the product when the operand signs differ.
- Divide:
  - Lo = quotient, Hi = remainder.
  - Quotient sign = sign(Rs) XOR sign(Rt).
  - Remainder sign = sign(Rs).
  - DIV 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0. This follows naturally from the magnitude path.
- Divide by zero (DIV or DIVU with RtData = 0):
  - E0 goes directly to FIX.
  - At E1: Hi = RsData (as latched), Lo = 0xFFFFFFFF, Done pulses.
- Start while Busy: ignored; no queuing.
- HiWr/LoWr:
  - Honoured only in IDLE, and take effect on the next edge.
  - Ignored while Busy.
  - If Start and HiWr/LoWr arrive in the same IDLE cycle, HiWr/LoWr win and Start is ignored.
- Between operations, Hi/Lo hold their values.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Op 100/101 (MADD/MADDU) run the multiply path.
  - FIX writes {Hi,Lo} = {Hi,Lo} + product, using the values held at E0, with 64-bit wrap-around.
  - Same 33-edge latency.
- Undefined: Op 100/101 are illegal and Start is ignored; no accumulator adder is synthesised.

Decomposition:
- Package mdu_pkg holds:
  - Op codes: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU.
  - State encoding: ST_IDLE, ST_CALC, ST_FIX.
  - MDU_CYCLES = 32.
  - DIV0_LO = 32'hFFFFFFFF.
- One sub-module, mdu_divstep: a combinational single restoring-divide step taking a 64-bit remainder/quotient pair and the divisor, producing the next pair. It is instantiated once in the CALC datapath.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi = 0xFFFFFFFE, Lo = 0x00000001; Done exactly 33 edges after the accepting edge; Busy high throughout.
- MULT -3 x 7 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB.
- DIV -7 / 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. DIVU 100 / 7 -> Lo = 14, Hi = 2. DIV 0x80000000 / -1 -> Lo = 0x80000000, Hi = 0.
- DIVU 0x1234 / 0 -> Hi = 0x00001234, Lo = 0xFFFFFFFF; Done one edge after accept.
- Start MULTU 5 x 5, reassert Start DIVU at edge 10, assert Rst at edge 20 -> second Start ignored; after Rst, Busy = 0, Done = 0, Hi = Lo = 0 immediately; a new MULTU 5 x 5 then gives Lo = 25.
- In IDLE: HiWr with RsData = 0xDEADBEEF, then LoWr with RsData = 0x12345678 -> Hi = 0xDEADBEEF, Lo = 0x12345678. LoWr while Busy leaves Lo unchanged. With MDU_MADD_EN, MADDU 2 x 3 onto Hi = 0, Lo = 0xFFFFFFFF gives Hi = 1, Lo = 5.
